// File: rtl/mult_div_pkg.sv
// Shared types for the iterative MULT/DIV engine.
package mult_div_pkg;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;
endpackage

// File: rtl/mult_div_seq_sign_fix.sv
// Final sign correction for HI/LO; only DIV needs negation,
// MULT passes the Booth product straight through.
module sign_fix
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic             neg_q,
  input  logic             neg_r,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  always_comb begin
    hi = acc;
    lo = q;
    if (op == OP_DIV) begin
      if (neg_r) hi = -acc;
      if (neg_q) lo = -q;
    end
  end
endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring)
// engine producing HI/LO for the multicycle datapath.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_1;
  logic             op_r;
  logic             neg_q;
  logic             neg_r;

  logic             dz;
  logic             accept;
  logic             step;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   bsum;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_sub;
  logic             ge;
  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign dz     = (op == OP_DIV) && (b == '0);
  assign accept = (state == IDLE) && start && !dz;
  assign step   = (state == RUN) && (cnt != '0);
  assign abs_a  = a[WIDTH-1] ? -a : a;
  assign abs_b  = b[WIDTH-1] ? -b : b;

  // One iteration of either algorithm on the shared {acc, q} pair.
  always_comb begin
    m_ext = {m[WIDTH-1], m};
    case ({q[0], q_1})
      2'b01:   bsum = acc + m_ext;
      2'b10:   bsum = acc - m_ext;
      default: bsum = acc;
    endcase
    r_sh  = {acc[WIDTH-1:0], q[WIDTH-1]};
    ge    = r_sh >= {1'b0, m};
    r_sub = r_sh - {1'b0, m};
    if (op_r == OP_MULT) begin
      acc_n = {bsum[WIDTH], bsum[WIDTH:1]};
      q_n   = {bsum[0], q[WIDTH-1:1]};
    end else begin
      acc_n = ge ? r_sub : r_sh;
      q_n   = {q[WIDTH-2:0], ge};
    end
  end

  sign_fix #(
    .WIDTH(WIDTH)
  ) u_fix (
    .op   (op_r),
    .neg_q(neg_q),
    .neg_r(neg_r),
    .acc  (acc[WIDTH-1:0]),
    .q    (q),
    .hi   (fix_hi),
    .lo   (fix_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      q_1   <= 1'b0;
      op_r  <= OP_MULT;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      acc  <= '0;
      q_1  <= 1'b0;
      op_r <= op;
      if (op == OP_DIV) begin
        q     <= abs_a;
        m     <= abs_b;
        neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        neg_r <= a[WIDTH-1];
      end else begin
        q     <= a;
        m     <= b;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end
    end else if (step) begin
      acc <= acc_n;
      q   <= q_n;
      q_1 <= q[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && dz) begin
            done     <= 1'b1;
            div_zero <= 1'b1;
          end else if (start) begin
            state <= RUN;
            cnt   <= CNT_W'(WIDTH);
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= FIX;
            busy  <= 1'b0;
          end
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq with WIDTH = 32.
module tb_mult_div_seq;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;
  localparam int LAT = W + 2;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  always #5 clk = ~clk;

  mult_div_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  function automatic exp_t model(logic o, logic [W-1:0] x,
                                 logic [W-1:0] y);
    longint sx, sy, p;
    exp_t   e;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz = 1'b0;
    if (o == 1'b0) begin
      p    = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == '0) begin
      e.hi = prev_hi;
      e.lo = prev_lo;
      e.dz = 1'b1;
    end else begin
      p    = sx / sy;
      e.lo = p[31:0];
      p    = sx % sy;
      e.hi = p[31:0];
    end
    return e;
  endfunction

  task automatic issue(input logic o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input bit now);
    exp_t e;
    if (!now) @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    e     = model(o, x, y);
    sb.push_back(e);
    if (!e.dz) begin
      prev_hi = e.hi;
      prev_lo = e.lo;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Edges after the accepting edge until done (-1 on timeout).
  task automatic wait_done(output int cyc, output int bc);
    cyc = -1;
    bc  = 0;
    for (int i = 0; i <= 60; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) bc++;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, div_zero, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h want 0",
               busy, done, div_zero, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int   cyc, bc;
    exp_t e;
    issue(1'b0, 32'd7, -32'sd3, 0);
    wait_done(cyc, bc);
    e = sb.pop_front();
    n_checks++;
    if (cyc != LAT || bc != LAT - 1) begin
      n_fail++;
      $display("FAIL mult_timing: done@%0d busy=%0d want %0d/%0d",
               cyc, bc, LAT, LAT - 1);
    end
    n_checks++;
    if ({hi, lo, div_zero} !== e) begin
      n_fail++;
      $display("FAIL mult_7x-3: hi=%h lo=%h dz=%b want %h %h %b",
               hi, lo, div_zero, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_div();
    int   cyc, bc;
    exp_t e;
    issue(1'b1, -32'sd7, 32'd2, 0);
    wait_done(cyc, bc);
    e = sb.pop_front();
    n_checks++;
    if (cyc != LAT) begin
      n_fail++;
      $display("FAIL div_timing: done@%0d want %0d", cyc, LAT);
    end
    n_checks++;
    if ({hi, lo, div_zero} !== e) begin
      n_fail++;
      $display("FAIL div_-7/2: hi=%h lo=%h dz=%b want %h %h %b",
               hi, lo, div_zero, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_div_zero();
    int   cyc, bc;
    exp_t e;
    issue(1'b1, 32'd7, 32'd3, 0);
    wait_done(cyc, bc);
    e = sb.pop_front();
    n_checks++;
    if ({hi, lo} !== {32'd1, 32'd2}) begin
      n_fail++;
      $display("FAIL dz_preload: hi=%h lo=%h want 1 2", hi, lo);
    end
    issue(1'b1, 32'd5, 32'd0, 0);
    wait_done(cyc, bc);
    e = sb.pop_front();
    n_checks++;
    if (cyc != 0 || bc != 0) begin
      n_fail++;
      $display("FAIL dz_timing: done@%0d busy=%0d want 0/0", cyc, bc);
    end
    n_checks++;
    if ({hi, lo, div_zero} !== e) begin
      n_fail++;
      $display("FAIL dz_result: hi=%h lo=%h dz=%b want %h %h %b",
               hi, lo, div_zero, e.hi, e.lo, e.dz);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, div_zero, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL dz_pulse: done=%b dz=%b busy=%b want 000",
               done, div_zero, busy);
    end
  endtask

  task automatic test_wrap();
    int           cyc, bc;
    exp_t         e;
    logic [W-1:0] xs[2];
    logic [W-1:0] ys[2];
    logic         os[2];
    xs = '{MIN, MIN};
    ys = '{32'hFFFF_FFFF, MIN};
    os = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      issue(os[i], xs[i], ys[i], 0);
      wait_done(cyc, bc);
      e = sb.pop_front();
      n_checks++;
      if (cyc != LAT || {hi, lo, div_zero} !== e) begin
        n_fail++;
        $display("FAIL wrap_%0d: done@%0d hi=%h lo=%h dz=%b want %h %h %b",
                 i, cyc, hi, lo, div_zero, e.hi, e.lo, e.dz);
      end
    end
  endtask

  task automatic test_ignore_start();
    int   ndone, dcyc;
    exp_t e;
    ndone = 0;
    dcyc  = -1;
    issue(1'b0, 32'd123456, -32'sd789, 0);
    for (int i = 1; i <= 40; i++) begin
      start = (i == 5 || i == 20);
      op    = 1'b1;
      a     = 32'd99;
      b     = '0;
      @(posedge clk);
      #1 start = 1'b0;
      if (done) begin
        ndone++;
        dcyc = i;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_checks++;
          if ({hi, lo, div_zero} !== e) begin
            n_fail++;
            $display("FAIL ignore_result: hi=%h lo=%h dz=%b want %h %h %b",
                     hi, lo, div_zero, e.hi, e.lo, e.dz);
          end
        end
      end
    end
    n_checks++;
    if (ndone != 1 || dcyc != LAT) begin
      n_fail++;
      $display("FAIL ignore_done: count=%0d at %0d want 1 at %0d",
               ndone, dcyc, LAT);
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    int   cyc, bc;
    exp_t e;
    issue(1'b0, -32'sd12345, 32'd6789, 0);
    for (int k = 0; k < 8; k++) begin
      wait_done(cyc, bc);
      e = sb.pop_front();
      n_checks++;
      if (cyc != (e.dz ? 0 : LAT) || {hi, lo, div_zero} !== e) begin
        n_fail++;
        $display("FAIL b2b_%0d: done@%0d hi=%h lo=%h dz=%b want %h %h %b",
                 k, cyc, hi, lo, div_zero, e.hi, e.lo, e.dz);
      end
      if (k < 7)
        issue(1'($urandom_range(0, 1)), $urandom,
              (k == 3) ? '0 : $urandom, 1);
    end
  endtask

  task automatic test_reset_mid();
    int   cyc, bc, ndone;
    exp_t e;
    ndone = 0;
    issue(1'b1, 32'd1000, 32'd7, 0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%b done=%b hi=%h lo=%h want 0",
               busy, done, hi, lo);
    end
    sb.delete();
    prev_hi = '0;
    prev_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL rst_nodone: got %0d done pulses want 0", ndone);
    end
    issue(1'b0, -32'sd5, 32'd6, 0);
    wait_done(cyc, bc);
    e = sb.pop_front();
    n_checks++;
    if (cyc != LAT || {hi, lo, div_zero} !== e) begin
      n_fail++;
      $display("FAIL rst_next: done@%0d hi=%h lo=%h want %h %h",
               cyc, hi, lo, e.hi, e.lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_wrap();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
